// File: rtl/riscv_timer_ctrl.sv
// riscv_timer_ctrl: control and consumer side of the 64-bit mtime counter.
// Generates the counter increment tick from a programmable prescaler and
// drives the counter load strobe on MTIME writes. Compares the counter value
// against mtimecmp to raise MTIP, and serves a 32-bit register port with a
// tear-free LO-then-HI mtime read.
// Optional feature macro: RISCV_TIMER_CMP_GUARD_EN. When defined, a CMP_LO
// write masks MTIP until the matching CMP_HI write.
//
// Register port handshake: i_wr_en and i_rd_en are single-cycle strobes that
// are always accepted; there is no backpressure. o_rd_valid pulses for exactly
// one cycle, one cycle after i_rd_en, and qualifies o_rd_data.
module riscv_timer_ctrl #(
  parameter int unsigned DIV_W   = 16,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_en,
  input  logic [2:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_rd_en,
  input  logic [2:0]  i_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  input  logic [63:0] i_mtime,
  output logic        o_cnt_incr_en,
  output logic        o_cnt_wr_en,
  output logic [63:0] o_cnt_wr_value,
  output logic        o_mtip
);

  localparam logic [2:0] ADDR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADDR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADDR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADDR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADDR_DIV      = 3'd4;
  localparam logic [2:0] ADDR_CTRL     = 3'd5;

  logic [63:0]      cmp_q;
  logic [DIV_W-1:0] div_q;
  logic             en_q;
  logic [DIV_W-1:0] presc_q;
  logic [31:0]      shadow_hi_q;
  logic [31:0]      rd_mux;
  logic             guard_block;
  logic             tick;

  logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_div, wr_ctrl;

  assign wr_mtime_lo = i_wr_en && (i_wr_addr == ADDR_MTIME_LO);
  assign wr_mtime_hi = i_wr_en && (i_wr_addr == ADDR_MTIME_HI);
  assign wr_cmp_lo   = i_wr_en && (i_wr_addr == ADDR_CMP_LO);
  assign wr_cmp_hi   = i_wr_en && (i_wr_addr == ADDR_CMP_HI);
  assign wr_div      = i_wr_en && (i_wr_addr == ADDR_DIV);
  assign wr_ctrl     = i_wr_en && (i_wr_addr == ADDR_CTRL);

  // A load into the counter wins over an increment in the same cycle.
  assign tick          = en_q && (presc_q == div_q) && !o_cnt_wr_en;
  assign o_cnt_incr_en = tick;

  // Configuration registers: mtimecmp, prescaler divisor, enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_q <= CMP_RST;
      div_q <= '0;
      en_q  <= 1'b0;
    end else begin
      if (wr_cmp_lo) cmp_q[31:0]  <= i_wr_data;
      if (wr_cmp_hi) cmp_q[63:32] <= i_wr_data;
      if (wr_div)    div_q        <= i_wr_data[DIV_W-1:0];
      if (wr_ctrl)   en_q         <= i_wr_data[0];
    end
  end

  // Prescaler: counts 0..div while enabled, restarts on tick, config write or load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (!en_q || wr_div || wr_ctrl || o_cnt_wr_en || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + DIV_W'(1);
    end
  end

  // Counter load: one-cycle strobe after an MTIME half write, other half kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_cnt_wr_en    <= 1'b0;
      o_cnt_wr_value <= '0;
    end else begin
      o_cnt_wr_en <= wr_mtime_lo || wr_mtime_hi;
      if (wr_mtime_lo)      o_cnt_wr_value <= {i_mtime[63:32], i_wr_data};
      else if (wr_mtime_hi) o_cnt_wr_value <= {i_wr_data, i_mtime[31:0]};
    end
  end

  // Read mux over pre-write register contents; HI comes from the shadow.
  always_comb begin
    rd_mux = '0;
    case (i_rd_addr)
      ADDR_MTIME_LO: rd_mux = i_mtime[31:0];
      ADDR_MTIME_HI: rd_mux = shadow_hi_q;
      ADDR_CMP_LO:   rd_mux = cmp_q[31:0];
      ADDR_CMP_HI:   rd_mux = cmp_q[63:32];
      ADDR_DIV:      rd_mux = 32'(div_q);
      ADDR_CTRL:     rd_mux = {31'd0, en_q};
      default:       rd_mux = '0;
    endcase
  end

  // Registered read response; a LO read snapshots the upper half for the HI read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
      shadow_hi_q <= '0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) o_rd_data <= rd_mux;
      if (i_rd_en && (i_rd_addr == ADDR_MTIME_LO)) shadow_hi_q <= i_mtime[63:32];
    end
  end

`ifdef RISCV_TIMER_CMP_GUARD_EN
  logic guard_q;

  // Guard: armed by a CMP_LO write, released by the CMP_HI write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guard_q <= 1'b0;
    end else if (wr_cmp_hi) begin
      guard_q <= 1'b0;
    end else if (wr_cmp_lo) begin
      guard_q <= 1'b1;
    end
  end

  assign guard_block = guard_q;
`else
  assign guard_block = 1'b0;
`endif

  // Interrupt: registered unsigned compare against the current cmp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_mtip <= 1'b0;
    end else begin
      o_mtip <= en_q && (i_mtime >= cmp_q) && !guard_block;
    end
  end

endmodule

// File: tb/tb_riscv_timer_ctrl.sv
// Testbench for riscv_timer_ctrl: directed steps followed by randomized
// register traffic, all checked against a behavioural model of the timer.
module tb_riscv_timer_ctrl;

  localparam int DIV_W = 16;
`ifdef RISCV_TIMER_CMP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [2:0]  i_wr_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_rd_en = 1'b0;
  logic [2:0]  i_rd_addr = '0;
  logic [31:0] o_rd_data;
  logic        o_rd_valid;
  logic [63:0] i_mtime = '0;
  logic        o_cnt_incr_en;
  logic        o_cnt_wr_en;
  logic [63:0] o_cnt_wr_value;
  logic        o_mtip;

  riscv_timer_ctrl #(.DIV_W(DIV_W), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .i_mtime(i_mtime),
    .o_cnt_incr_en(o_cnt_incr_en), .o_cnt_wr_en(o_cnt_wr_en),
    .o_cnt_wr_value(o_cnt_wr_value), .o_mtip(o_mtip)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // behavioural model of the timer's architectural state
  logic [63:0] m_cmp;
  int          m_div;
  logic        m_en;
  logic [31:0] m_shadow;
  logic        m_guard;
  int          m_phase;      // cycles since the prescaler last restarted
  logic        m_wr_en;
  logic [63:0] m_wr_val;
  logic [31:0] exp_q[$];     // expected read data, in request order

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_div = 0;
    m_en = 1'b0;
    m_shadow = '0;
    m_guard = 1'b0;
    m_phase = 0;
    m_wr_en = 1'b0;
    m_wr_val = '0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] reg_view(input logic [2:0] a);
    case (a)
      3'd0: return i_mtime[31:0];
      3'd1: return m_shadow;
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return 32'(m_div);
      3'd5: return {31'd0, m_en};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: check the tick of the current cycle, advance the model with
  // this cycle's inputs, cross the edge, check the registered outputs.
  task automatic cycle();
    logic exp_incr, n_rd_valid, n_mtip;
    exp_incr = m_en && !m_wr_en && ((m_phase % (m_div + 1)) == m_div);
    chk("incr_en", o_cnt_incr_en, exp_incr);
    n_rd_valid = i_rd_en;
    if (i_rd_en) exp_q.push_back(reg_view(i_rd_addr));
    if (i_rd_en && i_rd_addr == 3'd0) m_shadow = i_mtime[63:32];
    n_mtip = m_en && (i_mtime >= m_cmp) && !m_guard;
    m_phase = (!m_en || m_wr_en || (i_wr_en && (i_wr_addr == 3'd4 || i_wr_addr == 3'd5)))
              ? 0 : m_phase + 1;
    m_wr_en = i_wr_en && (i_wr_addr == 3'd0 || i_wr_addr == 3'd1);
    if (i_wr_en) begin
      case (i_wr_addr)
        3'd0: m_wr_val = {i_mtime[63:32], i_wr_data};
        3'd1: m_wr_val = {i_wr_data, i_mtime[31:0]};
        3'd2: begin m_cmp[31:0] = i_wr_data; if (GUARD) m_guard = 1'b1; end
        3'd3: begin m_cmp[63:32] = i_wr_data; m_guard = 1'b0; end
        3'd4: m_div = int'(i_wr_data[DIV_W-1:0]);
        3'd5: m_en = i_wr_data[0];
        default: ;
      endcase
    end
    @(posedge clk); #1;
    chk("rd_valid", o_rd_valid, n_rd_valid);
    if (n_rd_valid && exp_q.size() > 0) chk("rd_data", o_rd_data, exp_q.pop_front());
    chk("cnt_wr_en", o_cnt_wr_en, m_wr_en);
    if (m_wr_en) chk("cnt_wr_value", o_cnt_wr_value, m_wr_val);
    chk("mtip", o_mtip, n_mtip);
  endtask

  // driver tasks
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    cycle();
    i_wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a);
    i_rd_en = 1'b1; i_rd_addr = a;
    cycle();
    i_rd_en = 1'b0;
  endtask

  initial begin
    // reset
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_valid", o_rd_valid, 1'b0);
    chk("rst_mtip", o_mtip, 1'b0);
    chk("rst_incr", o_cnt_incr_en, 1'b0);
    chk("rst_wr_en", o_cnt_wr_en, 1'b0);
    rst = 1'b1;

    // cmp reset value readback
    bus_rd(3'd3);
    chk("cmp_hi_rst", o_rd_data, 32'hFFFF_FFFF);
    bus_rd(3'd2);
    chk("cmp_lo_rst", o_rd_data, 32'hFFFF_FFFF);

    // prescaler DIV=3: pulse every 4th cycle, first at the 4th cycle after CTRL write
    bus_wr(3'd4, 32'd3);
    bus_wr(3'd5, 32'd1);
    for (int i = 0; i < 12; i++) begin
      chk("div3_tick", o_cnt_incr_en, (i % 4) == 3);
      cycle();
    end
    bus_wr(3'd5, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("tick_stopped", o_cnt_incr_en, 1'b0);
      cycle();
    end

    // tear-free 64-bit read
    i_mtime = 64'h0000_0001_FFFF_FFFF;
    bus_rd(3'd0);
    chk("tear_lo", o_rd_data, 32'hFFFF_FFFF);
    i_mtime = 64'h0000_0002_0000_0000;
    bus_rd(3'd1);
    chk("tear_hi", o_rd_data, 32'h0000_0001);

    // compare ramp around cmp=0x100
    i_mtime = 64'hFE;
    bus_wr(3'd5, 32'd1);
    bus_wr(3'd2, 32'h100);
    bus_wr(3'd3, 32'h0);
    for (int v = 'hFE; v <= 'h101; v++) begin
      i_mtime = 64'(v);
      cycle();
      chk("ramp_mtip", o_mtip, v >= 'h100);
    end
    bus_wr(3'd2, 32'h200);
    cycle();
    chk("cmp_raise_mtip", o_mtip, 1'b0);
    bus_wr(3'd3, 32'h0);

    // mtime HI write while ticking every cycle
    bus_wr(3'd4, 32'd0);
    chk("div0_tick", o_cnt_incr_en, 1'b1);
    i_mtime = 64'h5_0000_0010;
    bus_wr(3'd1, 32'hABCD);
    chk("load_wr_en", o_cnt_wr_en, 1'b1);
    chk("load_value", o_cnt_wr_value, 64'h0000_ABCD_0000_0010);
    chk("load_no_incr", o_cnt_incr_en, 1'b0);
    cycle();

    // cmp guard sequence with mtime=0x50
    i_mtime = 64'h50;
    bus_wr(3'd2, 32'h100);
    bus_wr(3'd3, 32'h0);
    cycle();
    chk("guard_pre", o_mtip, 1'b0);
    bus_wr(3'd2, 32'h10);
    cycle();
    chk("guard_lo", o_mtip, !GUARD);
    bus_wr(3'd3, 32'h0);
    cycle();
    chk("guard_hi", o_mtip, 1'b1);

    // reset asserted with a load, a read and MTIP all pending
    i_rd_en = 1'b1; i_rd_addr = 3'd2;
    bus_wr(3'd0, 32'h1234);
    i_rd_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_wr_en", o_cnt_wr_en, 1'b0);
    chk("arst_rd_valid", o_rd_valid, 1'b0);
    chk("arst_mtip", o_mtip, 1'b0);
    chk("arst_incr", o_cnt_incr_en, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle();
    bus_rd(3'd5);
    chk("arst_ctrl", o_rd_data, 32'd0);

    // randomized register traffic against the model
    for (int n = 0; n < 600; n++) begin
      i_mtime = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 'h300));
      i_wr_en = ($urandom_range(0, 3) == 0);
      i_wr_addr = 3'($urandom_range(0, 7));
      case (i_wr_addr)
        3'd2: i_wr_data = $urandom_range(0, 'h300);
        3'd3: i_wr_data = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
        3'd4: i_wr_data = $urandom_range(0, 4);
        3'd5: i_wr_data = ($urandom_range(0, 3) == 0) ? 32'd0 : {$urandom_range(0, 1) == 1 ? 31'h7FFF_FFFF : 31'd0, 1'b1};
        default: i_wr_data = $urandom;
      endcase
      i_rd_en = ($urandom_range(0, 2) == 0);
      i_rd_addr = 3'($urandom_range(0, 7));
      cycle();
    end
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    cycle();

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
